// File: rtl/freq_disp_pkg.sv
// Shared constants for the frequency display: glyphs, converter states, widths.
package freq_disp_pkg;

  localparam int BIN_W       = 32;
  localparam int BCD_DIGITS  = 10;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_DIGITS = 8;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/freq_display_bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle.
module bin2bcd_seq
  import freq_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             load_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int n = 0; n < BCD_DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    load_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD;
        busy_d  = 1'b1;
      end
      LOAD: begin
        load_o  = 1'b1;
        bin_d   = bin_i;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/freq_display.sv
// 8-digit multiplexed 7-segment frequency readout with leading-zero blanking and overflow dashes.
module freq_display
  import freq_disp_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] freq_in,
  output logic [7:0]       seg,
  output logic [7:0]       sel,
  output logic             busy,
  output logic             ovf
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [BIN_W-1:0]                 freq_q, last_conv_q;
  logic [DISP_DIGITS-1:0][3:0]      disp_q;
  logic                             ovf_q;
  logic [PRE_W-1:0]                 pre_q;
  logic [2:0]                       idx_q;
  logic [7:0]                       seg_q, sel_q, seg_d, sel_d;
  logic                             conv_load, conv_done, tick;
  logic [BCD_W-1:0]                 conv_bcd;
  logic [DISP_DIGITS-1:0]           lit;
  logic [DISP_DIGITS-1:0][7:0]      glyph_v;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (freq_q != last_conv_q),
    .bin_i   (freq_q),
    .load_o  (conv_load),
    .busy_o  (busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // lit[k]: digit k or some higher digit is non-zero, so digit k must be drawn.
  assign lit[DISP_DIGITS-1] = |disp_q[DISP_DIGITS-1];
  for (genvar k = 0; k < DISP_DIGITS; k++) begin : g_digit
    if (k < DISP_DIGITS - 1) begin : g_lit
      assign lit[k] = (|disp_q[k]) | lit[k+1];
    end
    if (k == 0) begin : g_lsd
      assign glyph_v[k] = seg_glyph(disp_q[k]);
    end else begin : g_msd
      assign glyph_v[k] = lit[k] ? seg_glyph(disp_q[k]) : SEG_BLANK;
    end
  end

  assign tick  = (pre_q == PRE_W'(DIV - 1));
  assign seg_d = ovf_q ? SEG_DASH : glyph_v[idx_q];
  assign sel_d = ~(8'd1 << idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_q      <= '0;
      last_conv_q <= '0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      pre_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_BLANK;
      sel_q       <= 8'hFF;
    end else begin
      freq_q <= freq_in;
      if (conv_load) last_conv_q <= freq_q;
      if (conv_done) begin
        disp_q <= conv_bcd[4*DISP_DIGITS-1:0];
        ovf_q  <= |conv_bcd[BCD_W-1:4*DISP_DIGITS];
      end
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) idx_q <= idx_q + 3'd1;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_freq_display.sv
// Randomized checks of freq_display against a decimal-arithmetic display model.
module tb_freq_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] freq_in = '0;
  logic [7:0]  seg, sel;
  logic        busy, ovf;

  int vec = 0;
  int err = 0;
  int unsigned last_v = 0;
  logic [7:0] cap [8];

  freq_display #(.CLK_HZ(16), .SCAN_HZ(4)) dut (
    .clk(clk), .rst(rst), .freq_in(freq_in),
    .seg(seg), .sel(sel), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_glyph(input int unsigned v, input int k);
    logic [7:0] tbl [10];
    longint unsigned vv, p;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    vv = v;
    p  = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (vv > 64'd99_999_999) return 8'hBF;
    if (k > 0 && vv / p == 0) return 8'hFF;
    return tbl[(vv / p) % 10];
  endfunction

  // Walk the scan until every digit slot has been observed once.
  task automatic capture_display();
    logic [7:0] seen = '0;
    int cyc = 0;
    for (int k = 0; k < 8; k++) cap[k] = 'x;
    while (seen != 8'hFF && cyc < 64) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 8; k++)
        if (sel === ~(8'd1 << k) && !seen[k]) begin
          cap[k]  = seg;
          seen[k] = 1'b1;
        end
    end
    if (seen != 8'hFF) begin
      vec++; err++;
      $display("FAIL capture_timeout: slots seen %b, required 11111111", seen);
    end
  endtask

  task automatic check_display(input string tag, input int unsigned v);
    capture_display();
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (cap[k] !== ref_glyph(v, k)) begin
        err++;
        $display("FAIL %s digit%0d: got %h, expected %h (value %0d)", tag, k, cap[k], ref_glyph(v, k), v);
      end
    end
    vec++;
    if (ovf !== (v > 32'd99_999_999)) begin
      err++;
      $display("FAIL %s ovf: got %b, expected %b", tag, ovf, (v > 32'd99_999_999));
    end
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int limit);
    int c = 0;
    while (busy !== lvl && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (busy !== lvl) begin
      vec++; err++;
      $display("FAIL %s busy_wait: busy %b, required %b within %0d clk", tag, busy, lvl, limit);
    end
  endtask

  task automatic run_conv(input string tag, input int unsigned v);
    int cnt = 0;
    @(negedge clk);
    freq_in = v;
    wait_busy(tag, 1'b1, 10);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    vec++;
    if (cnt != 34) begin
      err++;
      $display("FAIL %s busy_len: got %0d clk, expected 34", tag, cnt);
    end
    last_v = v;
    check_display(tag, v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec += 3;
    if (seg !== 8'hFF) begin err++; $display("FAIL reset_seg: got %h, expected ff", seg); end
    if (sel !== 8'hFF) begin err++; $display("FAIL reset_sel: got %h, expected ff", sel); end
    if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (sel !== 8'hFE || seg !== 8'hC0) begin
      err++;
      $display("FAIL reset_slot0: got sel %h seg %h, expected fe c0", sel, seg);
    end
    check_display("reset_disp", 0);
  endtask

  task automatic test_basic();
    run_conv("v1234", 1234);
  endtask

  task automatic test_boundary();
    run_conv("max8", 99_999_999);
    run_conv("ovf_lo", 100_000_000);
    run_conv("ovf_hi", 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    int unsigned v;
    for (int i = 0; i < 6; i++) begin
      case (i % 4)
        0: v = $urandom % 10;
        1: v = $urandom % 100_000;
        2: v = $urandom % 100_000_000;
        default: v = $urandom;
      endcase
      if (v == last_v) v = v + 1;
      run_conv($sformatf("rand%0d", i), v);
    end
  endtask

  task automatic test_defer();
    run_conv("pre_defer", 3);
    @(negedge clk);
    freq_in = 5;
    wait_busy("defer5", 1'b1, 10);
    repeat (10) @(negedge clk);
    freq_in = 7;
    wait_busy("defer5_end", 1'b0, 60);
    @(negedge clk);
    vec++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL defer_rearm: busy %b, expected 1", busy);
    end
    check_display("defer5", 5);
    wait_busy("defer7_end", 1'b0, 60);
    last_v = 7;
    check_display("defer7", 7);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    freq_in = 4321;
    wait_busy("mid", 1'b1, 10);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec += 2;
    if (busy !== 1'b0) begin err++; $display("FAIL mid_busy: got %b, expected 0", busy); end
    if (sel !== 8'hFF) begin err++; $display("FAIL mid_sel: got %h, expected ff", sel); end
    rst = 1'b0;
    check_display("mid_zero", 0);
    wait_busy("mid_redo", 1'b0, 60);
    check_display("mid_redo", 4321);
  endtask

  task automatic test_scan();
    logic [7:0] cur;
    logic [7:0] exp_next;
    int held, idx, c;
    cur = sel;
    c = 0;
    while (sel === cur && c < 20) begin @(negedge clk); c++; end
    for (int t = 0; t < 16; t++) begin
      cur  = sel;
      held = 0;
      while (sel === cur && held < 20) begin @(negedge clk); held++; end
      idx = 0;
      for (int k = 0; k < 8; k++) if (cur === ~(8'd1 << k)) idx = k;
      exp_next = ~(8'd1 << ((idx + 1) % 8));
      vec += 2;
      if (held != 4) begin
        err++;
        $display("FAIL scan_hold%0d: sel %h held %0d clk, expected 4", t, cur, held);
      end
      if (sel !== exp_next) begin
        err++;
        $display("FAIL scan_step%0d: after %h got %h, expected %h", t, cur, sel, exp_next);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_defer();
    test_reset_mid();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
